// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response and memory-side bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int NCORES = 16,
  parameter int AW     = 16,
  parameter int DW     = 16
) ();
  logic [NCORES-1:0]    reqValid;
  logic [NCORES-1:0]    reqWrite;
  logic [NCORES*AW-1:0] reqAddr;
  logic [NCORES*DW-1:0] reqData;
  logic [NCORES-1:0]    reqGrant;
  logic [NCORES-1:0]    rspValid;
  logic [DW-1:0]        rspData;
  logic                 memEn;
  logic                 memWe;
  logic [AW-1:0]        memAddr;
  logic [DW-1:0]        memWdata;
  logic                 memReady;
  logic [DW-1:0]        memRdata;
  logic [15:0]          conflictCount;

  // Arbiter side: consumes core requests and memory replies, drives grants and memory controls
  modport master (
    input  reqValid, reqWrite, reqAddr, reqData, memReady, memRdata,
    output reqGrant, rspValid, rspData, memEn, memWe, memAddr, memWdata, conflictCount
  );

  // Core/memory side: the mirror image
  modport slave (
    output reqValid, reqWrite, reqAddr, reqData, memReady, memRdata,
    input  reqGrant, rspValid, rspData, memEn, memWe, memAddr, memWdata, conflictCount
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter in front of the shared single-port memory
module mem_arbiter #(
  parameter int NCORES = 16,
  parameter int AW     = 16,
  parameter int DW     = 16
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);
  localparam int              PW       = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [PW-1:0]   LAST_IDX = PW'(NCORES - 1);
  localparam logic [NCORES-1:0] ONE    = NCORES'(1);

  logic [PW-1:0]     r_ptr;
  // Owner of the in-flight access while memEn is high; also masks that core for one arbitration edge
  logic [NCORES-1:0] r_last_grant;
  logic [NCORES-1:0] r_grant;
  logic [NCORES-1:0] r_rsp_valid;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [AW-1:0]     r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;
  logic [15:0]       r_conflict_cnt;

  logic              w_accept;
  logic              w_arb;
  logic [NCORES-1:0] w_elig;
  logic              w_conflict;
  logic              w_found;
  logic [PW-1:0]     w_winner;
  logic [PW-1:0]     w_scan;
  logic [NCORES-1:0] w_win_onehot;

  assign w_accept     = r_mem_en & bus.memReady;
  assign w_arb        = ~r_mem_en | bus.memReady;
  assign w_elig       = bus.reqValid & ~r_last_grant;
  assign w_conflict   = ($countones(w_elig) >= 2);
  assign w_win_onehot = ONE << w_winner;

  // Pick the first eligible core at or after the rotating pointer, wrapping at NCORES
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_scan   = r_ptr;
    for (int i = 0; i < NCORES; i++) begin
      if (!w_found && w_elig[w_scan]) begin
        w_found  = 1'b1;
        w_winner = w_scan;
      end
      w_scan = (w_scan == LAST_IDX) ? '0 : w_scan + 1'b1;
    end
  end

  // Issue registers, rotation state, read-response routing and the saturating conflict counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr          <= '0;
      r_last_grant   <= '0;
      r_grant        <= '0;
      r_rsp_valid    <= '0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_rsp_valid <= (w_accept && !r_mem_we) ? r_last_grant : '0;
      if (w_arb) begin
        if (w_found) begin
          r_grant      <= w_win_onehot;
          r_last_grant <= w_win_onehot;
          r_mem_en     <= 1'b1;
          r_mem_we     <= bus.reqWrite[w_winner];
          r_mem_addr   <= bus.reqAddr[w_winner*AW +: AW];
          r_mem_wdata  <= bus.reqData[w_winner*DW +: DW];
          r_ptr        <= (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
        end else begin
          r_grant      <= '0;
          r_last_grant <= '0;
          r_mem_en     <= 1'b0;
        end
        if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
          r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
      end else begin
        // Stall: the issued access and its owner hold, only the grant pulse ends
        r_grant <= '0;
      end
    end
  end

  assign bus.reqGrant      = r_grant;
  assign bus.rspValid      = r_rsp_valid;
  assign bus.rspData       = bus.memRdata;
  assign bus.memEn         = r_mem_en;
  assign bus.memWe         = r_mem_we;
  assign bus.memAddr       = r_mem_addr;
  assign bus.memWdata      = r_mem_wdata;
  assign bus.conflictCount = r_conflict_cnt;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter between the per-core memory request ports and the single-ported shared program/data memory. Each core presents at most one outstanding read or write. The arbiter grants one request per cycle, drives registered memory controls, and routes synchronous read data back to the requesting core. It replaces the current scheme where all cores write the memory array on the same edge with no ordering.

## Interface
- NCORES, 16, number of requesting cores (2..16)
- AW, 16, address width
- DW, 16, data width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- reqValid  in  NCORES  per-core request pending; held until grant
- reqWrite  in  NCORES  per-core request type, 1 = write, 0 = read
- reqAddr  in  NCORES*AW  core i address at [i*AW +: AW]
- reqData  in  NCORES*DW  core i write data at [i*DW +: DW]
- reqGrant  out  NCORES  one-hot, one-cycle pulse, registered
- rspValid  out  NCORES  one-hot, one-cycle read-data-valid, registered
- rspData  out  DW  read data, combinational copy of memRdata
- memEn  out  1  memory access request, registered
- memWe  out  1  write enable, registered
- memAddr  out  AW  registered
- memWdata  out  DW  registered
- memReady  in  1  memory accepts the access at this edge when memEn is high
- memRdata  in  DW  read data, valid in the cycle after an accepted read
- conflictCount  out  16  saturating count of arbitration edges with at least 2 eligible requesters

## Operation
- State: rotating pointer ptr (log2 NCORES bits), lastGrant mask (NCORES bits), pending-read id, issue registers.
- An access is accepted at an edge where memEn is 1 and memReady is 1.
- An arbitration edge is any edge where memEn is 0, or the current access is accepted.
- Eligible set = reqValid & ~lastGrant.
- On an arbitration edge with a non-empty eligible set:
  - Winner = first eligible index scanning ptr, ptr+1, ... with wrap modulo NCORES.
  - Registers load: reqGrant <= onehot(winner); memEn <= 1; memWe <= reqWrite[winner]; memAddr and memWdata <= winner's slices.
  - ptr <= (winner+1) mod NCORES. lastGrant <= onehot(winner).
- On an arbitration edge with an empty eligible set: memEn <= 0, reqGrant <= 0, lastGrant <= 0. ptr is unchanged.
- On a stall edge (memEn 1, memReady 0):
  - memEn, memWe, memAddr and memWdata hold.
  - reqGrant <= 0. No new winner. ptr and lastGrant hold.
- Requester rule: after seeing reqGrant[i], core i updates its request fields at the next edge. Its reqValid is ignored for exactly one arbitration edge through lastGrant.
- Reads: at an edge accepting a read from core k, rspValid <= onehot(k). Otherwise rspValid <= 0. Core k samples rspData while rspValid[k] is 1.
- Writes produce no response. A write is complete at its acceptance edge.
- conflictCount increments by 1 on each arbitration edge where popcount(eligible) >= 2. It saturates at 16'hFFFF.
- Reset, asynchronous, all outputs and state to 0:
  - reqGrant, rspValid, memEn, memWe, memAddr, memWdata, conflictCount all 0.
  - ptr 0, lastGrant 0.
  - An in-flight access or read response is dropped. No memory write is issued after reset asserts.

## Timing
- Grant latency: reqValid high before edge N with an empty competing set gives reqGrant and memEn high after edge N.
- Throughput: with memReady held at 1, one access per cycle. A single core alone can be granted at most every other cycle, because of the lastGrant mask.
- Read latency:
  - Request granted at edge N and accepted at edge N+1.
  - rspValid is high from edge N+1 to N+2.
  - memRdata must be valid in that same cycle.
- Each stall cycle adds one cycle to the latency of the access and of any later grant.
- Fairness: with all NCORES requesting continuously, each core is granted exactly once in every NCORES consecutive grants.
- reqGrant and rspValid are never high for more than one cycle per access. Each has at most one bit set.

## Test plan
- Reset check: assert rst mid-access with memEn=1 -> all outputs are 0 immediately (asynchronous), and no write occurs afterwards.
- Single read: core 3 reads addr 0x0010 with memRdata=0xBEEF, memReady=1.
  - reqGrant=0x0008 after edge N.
  - memEn=1, memWe=0, memAddr=0x0010.
  - rspValid=0x0008 with rspData=0xBEEF after edge N+1.
- All 16 cores write addr=i, data=i*2, reqValid held until grant -> grants follow order 0,1,...,15 on consecutive edges; mem[i]=2i; conflictCount=15.
- Stall: core 5 write with memReady=0 for 3 cycles -> memEn/memAddr held for 3 cycles; no other grants; reqGrant pulses once.
- Wrap and mask:
  - ptr=14, cores 1 and 15 request: grant 15, then 1.
  - Core 1 alone requesting back-to-back is granted at edges N and N+2, never at N+1.
- Saturation: preload conflictCount to 16'hFFFE and apply 3 conflict edges -> counter reads 16'hFFFF and holds.
